// File: rtl/frogger_level_ctrl_if.sv
// Frogger level controller bus.
//   Inputs to the controller:    start (active-low button), goal pulse, hit pulse.
//   Outputs from the controller: level select, lives, respawn pulse,
//                                run / gameOver / win status.
// The master modport is the event source and status sink.
// The slave modport is the controller itself.
interface frogger_level_ctrl_if;
  logic       LEVELCTRL_start_InLow;
  logic       LEVELCTRL_goal_In;
  logic       LEVELCTRL_hit_In;
  logic [1:0] LEVELCTRL_level_OutBUS;
  logic [1:0] LEVELCTRL_lives_OutBUS;
  logic       LEVELCTRL_frogRespawn_Out;
  logic       LEVELCTRL_run_Out;
  logic       LEVELCTRL_gameOver_Out;
  logic       LEVELCTRL_win_Out;

  modport master (
    output LEVELCTRL_start_InLow, LEVELCTRL_goal_In, LEVELCTRL_hit_In,
    input  LEVELCTRL_level_OutBUS, LEVELCTRL_lives_OutBUS, LEVELCTRL_frogRespawn_Out,
           LEVELCTRL_run_Out, LEVELCTRL_gameOver_Out, LEVELCTRL_win_Out
  );

  modport slave (
    input  LEVELCTRL_start_InLow, LEVELCTRL_goal_In, LEVELCTRL_hit_In,
    output LEVELCTRL_level_OutBUS, LEVELCTRL_lives_OutBUS, LEVELCTRL_frogRespawn_Out,
           LEVELCTRL_run_Out, LEVELCTRL_gameOver_Out, LEVELCTRL_win_Out
  );
endinterface

// File: rtl/frogger_level_ctrl.sv
// Frogger level/lives sequencer.
// It tracks start / goal / hit events and drives the level mux select.
// It also produces the remaining lives count, frog respawn pulses, and the
// run / gameOver / win status.
// Ports:
//   LEVELCTRL_CLOCK_50      system clock, rising edge
//   LEVELCTRL_RESET_InHigh  synchronous active-high reset
//   bus                     frogger_level_ctrl_if.slave (events in, status out)
// Every output is a flop.
module frogger_level_ctrl #(
  parameter int NUM_LEVELS   = 4,
  parameter int LIVES_INIT   = 3,
  parameter int PAUSE_CYCLES = 16,
  parameter int PAUSE_WIDTH  = 5
) (
  input logic                 LEVELCTRL_CLOCK_50,
  input logic                 LEVELCTRL_RESET_InHigh,
  frogger_level_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, PLAY, PAUSE_UP, PAUSE_DEAD, GAME_OVER, WIN
  } state_t;

  localparam logic [1:0]             LAST_LEVEL = 2'(NUM_LEVELS - 1);
  localparam logic [1:0]             LIVES_RST  = 2'(LIVES_INIT);
  localparam logic [PAUSE_WIDTH-1:0] PAUSE_LOAD = PAUSE_WIDTH'(PAUSE_CYCLES - 1);

  state_t                 state, stateNext;
  logic [1:0]             level, levelNext;
  logic [1:0]             lives, livesNext;
  logic [PAUSE_WIDTH-1:0] pauseCnt, pauseCntNext;
  logic                   respawnNext;
  logic                   startQ;
  logic                   startEvt;
  logic                   respawn, run, gameOver, win;

  // Falling edge of the active-low button.
  // Holding it low gives a single event.
  assign startEvt = startQ & ~bus.LEVELCTRL_start_InLow;

  always_comb begin
    stateNext    = state;
    levelNext    = level;
    livesNext    = lives;
    pauseCntNext = pauseCnt;
    respawnNext  = 1'b0;
    unique case (state)
      IDLE, GAME_OVER, WIN: begin
        if (startEvt) begin
          stateNext   = PLAY;
          levelNext   = 2'd0;
          livesNext   = LIVES_RST;
          respawnNext = 1'b1;
        end
      end
      PLAY: begin
        // A hit wins over a simultaneous goal.
        if (bus.LEVELCTRL_hit_In) begin
          if (lives > 2'd1) begin
            livesNext    = lives - 2'd1;
            pauseCntNext = PAUSE_LOAD;
            stateNext    = PAUSE_DEAD;
          end else begin
            livesNext = 2'd0;
            stateNext = GAME_OVER;
          end
        end else if (bus.LEVELCTRL_goal_In) begin
          if (level < LAST_LEVEL) begin
            // The new level is selected at once, so its pattern settles during the pause.
            levelNext    = level + 2'd1;
            pauseCntNext = PAUSE_LOAD;
            stateNext    = PAUSE_UP;
          end else begin
            stateNext = WIN;
          end
        end
      end
      PAUSE_UP, PAUSE_DEAD: begin
        // Count 0 is the last frozen cycle.
        // Loading PAUSE_CYCLES-1 gives exactly PAUSE_CYCLES cycles with run low.
        if (pauseCnt == '0) begin
          stateNext   = PLAY;
          respawnNext = 1'b1;
        end else begin
          pauseCntNext = pauseCnt - PAUSE_WIDTH'(1);
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge LEVELCTRL_CLOCK_50) begin
    if (LEVELCTRL_RESET_InHigh) begin
      state    <= IDLE;
      level    <= 2'd0;
      lives    <= LIVES_RST;
      pauseCnt <= '0;
      startQ   <= 1'b1;
      respawn  <= 1'b0;
      run      <= 1'b0;
      gameOver <= 1'b0;
      win      <= 1'b0;
    end else begin
      state    <= stateNext;
      level    <= levelNext;
      lives    <= livesNext;
      pauseCnt <= pauseCntNext;
      startQ   <= bus.LEVELCTRL_start_InLow;
      respawn  <= respawnNext;
      // Status flags are decoded from the next state.
      // Each flag is therefore a flop that is aligned with the state register.
      run      <= (stateNext == PLAY);
      gameOver <= (stateNext == GAME_OVER);
      win      <= (stateNext == WIN);
    end
  end

  assign bus.LEVELCTRL_level_OutBUS    = level;
  assign bus.LEVELCTRL_lives_OutBUS    = lives;
  assign bus.LEVELCTRL_frogRespawn_Out = respawn;
  assign bus.LEVELCTRL_run_Out         = run;
  assign bus.LEVELCTRL_gameOver_Out    = gameOver;
  assign bus.LEVELCTRL_win_Out         = win;

endmodule
